meb_fee_readout_master: RTL and testbench
=========================================

// Module: meb_fee_readout_master
// PURPOSE
// - MEB-side counterpart of the FEE hit/readout link: watches the FEE hit strobe and busy line, and runs as SPI master on the FEE readout port.
// - Clocks FEE frame bytes in, MSB first, and presents them on a byte stream with valid/ready.
// - Drives meb_hold to the FEE whenever the downstream stream stalls.
// - Sits on the MEB FPGA between the FEE cable pins and the MEB event buffer.
// PARAMETERS
// - CLK_DIV        4     sysclk cycles per SPI half-period; must be >=2.
// - IDLE_BYTE      8'hFF byte value the FEE shifts out when it has no data.
// - IDLE_STOP      2     consecutive IDLE_BYTE values that end a burst; range 1..15.
// - MAX_BURST      1024  byte cap per burst; when reached the burst ends and burst_abort is set.
// - MOSI_CMD       8'h00 byte shifted out on mosi for every read byte.
// PORTS
// - sysclk       in  1   single clock for the whole block.
// - rst          in  1   synchronous reset, active-high.
// - enable       in  1   0: finish the current byte, then stay IDLE.
// - force_read   in  1   1-cycle pulse; starts a burst with no hit.
// - fee_hit_n    in  1   async, active-low, >=1 FEE-clock pulse per hit.
// - fee_busy     in  1   async; FEE is filling its buffer.
// - spi_clk      out 1   SPI mode 0; idle low.
// - spi_mosi     out 1   MOSI_CMD bits.
// - spi_miso     in  1   FEE data; sampled on the spi_clk rising edge.
// - meb_hold     out 1   1 = MEB cannot accept data; FEE must pause.
// - m_data       out 8   received byte.
// - m_valid      out 1   m_data valid.
// - m_ready      in  1   downstream accepts.
// - hit_count    out 16  synchronised hit edges seen; wraps.
// - burst_count  out 16  completed bursts; wraps.
// - burst_abort  out 1   sticky; set when MAX_BURST is hit; cleared only by rst.
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counters 0, hit_pending 0.
// - Sync: fee_hit_n and fee_busy each pass through 2 flops.
//   - A 1->0 transition of synced hit sets hit_pending and increments hit_count.
//   - Detection latency is 3 sysclk from the async edge.
// - FSM states: IDLE, WAIT_BUSY, SHIFT, GAP.
//   - IDLE -> WAIT_BUSY when enable & (hit_pending | force_read); hit_pending clears on entry.
//   - WAIT_BUSY -> SHIFT once synced fee_busy==0. It waits indefinitely; rst is the only escape.
//   - SHIFT: 8 spi_clk periods of 2*CLK_DIV sysclk each.
//     - mosi updates on the falling edge, and the first bit is set up on entry.
//     - miso is sampled on the rising edge.
//     - The last falling edge returns spi_clk low and enters GAP.
//   - GAP: 1 cycle minimum. Load the byte into the output register when it is free, then apply the end checks in order:
//     1. idle_run>=IDLE_STOP → IDLE.
//     2. byte_cnt==MAX_BURST → IDLE, set burst_abort.
//     3. !enable → IDLE.
//     4. Otherwise → SHIFT.
//     - Each exit to IDLE increments burst_count.
// - idle_run: incremented when a byte equals IDLE_BYTE, reset to 0 otherwise.
//   - IDLE bytes are still forwarded on m_data; downstream strips them.
// - Output register: one byte deep.
//   - m_valid holds with m_data stable until m_valid&m_ready.
//   - If a new byte is done while the register is full, the FSM stays in GAP with spi_clk low. No byte is ever dropped.
//   - Load and accept in the same cycle are allowed (pass-through, no bubble).
// - meb_hold = m_valid & ~m_ready, registered (1-cycle delay).
// - Hits during a burst set hit_pending and start a new burst after IDLE. Multiple hits collapse into one pending flag.
// - force_read while not IDLE is ignored.
// - rst mid-byte: spi_clk goes low on the next edge; the partial byte is discarded.
// STRUCTURE
// - Shared package meb_fee_pkg holds:
//   - the state enum typedef;
//   - localparams for SPI mode and the default IDLE_BYTE;
//   - the byte_t typedef.
// - Sub-module meb_sync2 (2-flop synchroniser, WIDTH param) is instantiated for fee_hit_n and fee_busy.
// - Everything else is inline.
// TESTING
// - Hit readout: fee_hit_n low pulse, FEE model returns A5,3C,FF,FF with m_ready=1.
//   - Required: m_data A5,3C,FF,FF; burst_count=1; hit_count=1; spi_clk period 8 sysclk.
// - Backpressure: m_ready=0 after the first byte.
//   - Required: meb_hold=1 one cycle later; spi_clk stays low; no byte lost.
//   - Release: the second byte appears on the cycle m_ready=1.
// - Busy gating: fee_busy=1, then a hit.
//   - Required: no spi_clk edges until busy has been 0 for 2 cycles; the burst then proceeds.
// - Cap: MAX_BURST=4, FEE never idles.
//   - Required: exactly 4 bytes; burst_abort=1; FSM IDLE.
// - Hit during burst: a second hit mid-burst.
//   - Required: after the IDLE_STOP end, a new burst starts automatically; hit_count=2.
// - Reset mid-SHIFT (bit 3): rst for 1 cycle.
//   - Required: spi_clk=0 next cycle; m_valid=0; counters=0; no partial byte is output.

Source files
------------

// File: rtl/meb_fee_pkg.sv
// Shared types and constants for the MEB-side FEE readout master.
package meb_fee_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    SHIFT,
    GAP
  } state_t;

  // {CPOL, CPHA}: mode 0, clock idles low, FEE data sampled on the rising edge.
  localparam logic [1:0] SPI_MODE          = 2'b00;
  localparam byte_t      DEFAULT_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/meb_sync2.sv
// Two-flop synchroniser for asynchronous FEE cable inputs; 2 sysclk latency, no backpressure.
module meb_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/meb_fee_readout_master.sv
// SPI master draining FEE frames in bursts onto a one-byte valid/ready register.
// A byte lands 1 cycle after its last spi_clk fall; a full register parks the FSM in GAP and raises meb_hold.
module meb_fee_readout_master
  import meb_fee_pkg::*;
#(
  parameter int    CLK_DIV   = 4,
  parameter byte_t IDLE_BYTE = DEFAULT_IDLE_BYTE,
  parameter int    IDLE_STOP = 2,
  parameter int    MAX_BURST = 1024,
  parameter byte_t MOSI_CMD  = 8'h00
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        force_read,
  input  logic        fee_hit_n,
  input  logic        fee_busy,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        meb_hold,
  output byte_t       m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] hit_count,
  output logic [15:0] burst_count,
  output logic        burst_abort
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_t           state, state_nxt;
  logic             hit_s, busy_s, hit_d, hit_fall, hit_pending;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_idx;
  byte_t            shreg;
  logic [3:0]       idle_run, idle_run_nxt;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_nxt;
  logic             half_tick, out_free, start, enter_shift, load, end_burst, cap_hit;

  meb_sync2 #(.WIDTH(1)) u_sync_hit  (.sysclk(sysclk), .rst(rst), .d(fee_hit_n), .q(hit_s));
  meb_sync2 #(.WIDTH(1)) u_sync_busy (.sysclk(sysclk), .rst(rst), .d(fee_busy),  .q(busy_s));

  assign hit_fall     = hit_d & ~hit_s;
  assign half_tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign out_free     = ~m_valid | m_ready;
  assign idle_run_nxt = (shreg == IDLE_BYTE) ? idle_run + 4'd1 : 4'd0;
  assign byte_cnt_nxt = byte_cnt + CNT_W'(1);
  assign enter_shift  = (state_nxt == SHIFT) && (state != SHIFT);

  always_ff @(posedge sysclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // End checks look at the byte being loaded this cycle, so the counts use their next values.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load      = 1'b0;
    end_burst = 1'b0;
    cap_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (hit_pending || force_read)) begin
          state_nxt = WAIT_BUSY;
          start     = 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (!busy_s) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (half_tick && spi_clk && (bit_idx == 3'd7)) state_nxt = GAP;
      end
      GAP: begin
        if (out_free) begin
          load = 1'b1;
          if (idle_run_nxt >= 4'(IDLE_STOP)) begin
            end_burst = 1'b1;
          end else if (byte_cnt_nxt == CNT_W'(MAX_BURST)) begin
            end_burst = 1'b1;
            cap_hit   = 1'b1;
          end else if (!enable) begin
            end_burst = 1'b1;
          end
          state_nxt = end_burst ? IDLE : SHIFT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      hit_d       <= 1'b0;
      hit_pending <= 1'b0;
      hit_count   <= '0;
      burst_count <= '0;
      burst_abort <= 1'b0;
      div_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      idle_run    <= '0;
      byte_cnt    <= '0;
      spi_clk     <= SPI_MODE[1];
      spi_mosi    <= 1'b0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      meb_hold    <= 1'b0;
    end else begin
      hit_d <= hit_s;
      // A fresh hit wins over the clear so a hit landing on burst start is not lost.
      if (hit_fall) begin
        hit_pending <= 1'b1;
        hit_count   <= hit_count + 16'd1;
      end else if (start) begin
        hit_pending <= 1'b0;
      end

      if (start) begin
        idle_run <= '0;
        byte_cnt <= '0;
      end

      if (enter_shift) begin
        div_cnt  <= '0;
        bit_idx  <= '0;
        spi_clk  <= SPI_MODE[1];
        spi_mosi <= MOSI_CMD[7];
      end else if (state == SHIFT) begin
        div_cnt <= half_tick ? '0 : div_cnt + DIV_W'(1);
        if (half_tick) begin
          spi_clk <= ~spi_clk;
          if (!spi_clk) begin
            shreg <= {shreg[6:0], spi_miso};
          end else begin
            bit_idx  <= bit_idx + 3'd1;
            spi_mosi <= MOSI_CMD[3'd6 - bit_idx];
          end
        end
      end

      if (load) begin
        idle_run <= idle_run_nxt;
        byte_cnt <= byte_cnt_nxt;
        if (end_burst) burst_count <= burst_count + 16'd1;
        if (cap_hit)   burst_abort <= 1'b1;
      end

      if (load) begin
        m_data  <= shreg;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      meb_hold <= m_valid & ~m_ready;
    end
  end

endmodule

// File: tb/tb_meb_fee_readout_master.sv
// Directed bench: FEE SPI slave model serving byte lists, stream monitor, one task per scenario.
module tb_meb_fee_readout_master;
  import meb_fee_pkg::*;

  logic        sysclk_100 = 1'b0;
  logic        rst = 1'b1, enable = 1'b1, force_read = 1'b0;
  logic        fee_hit_n = 1'b1, fee_busy = 1'b0, m_ready = 1'b1;
  logic        spi_clk, spi_mosi, spi_miso, meb_hold, m_valid, burst_abort;
  logic [7:0]  m_data;
  logic [15:0] hit_count, burst_count;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 sysclk_100 = ~sysclk_100;

  meb_fee_readout_master #(.MAX_BURST(4)) dut (
    .sysclk(sysclk_100), .rst(rst), .enable(enable), .force_read(force_read),
    .fee_hit_n(fee_hit_n), .fee_busy(fee_busy), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .meb_hold(meb_hold), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .hit_count(hit_count), .burst_count(burst_count), .burst_abort(burst_abort)
  );

  // FEE slave: MSB first, shifts on the spi_clk fall, returns 8'hFF once its list is used up.
  logic [7:0] fee_mem [16];
  int fee_len = 0, fee_base = 0, fee_bitcnt = 0, fee_rel;

  always @(negedge spi_clk) fee_bitcnt <= fee_bitcnt + 1;

  always_comb begin
    fee_rel  = fee_bitcnt - fee_base;
    spi_miso = 1'b1;
    if (fee_rel / 8 < fee_len) spi_miso = fee_mem[fee_rel / 8][7 - fee_rel % 8];
  end

  logic [7:0] got [$];
  int spi_rises = 0;

  always @(negedge sysclk_100) if (m_valid === 1'b1 && m_ready === 1'b1) got.push_back(m_data);
  always @(posedge spi_clk) spi_rises <= spi_rises + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge sysclk_100);
      #2;
    end
  endtask

  task automatic fee_load(input logic [63:0] bytes, input int n);
    for (int i = 0; i < 8; i++) fee_mem[i] = bytes[63 - 8*i -: 8];
    fee_len  = n;
    fee_base = fee_bitcnt;
  endtask

  task automatic hit_pulse();
    fee_hit_n = 1'b0;
    step(2);
    fee_hit_n = 1'b1;
  endtask

  task automatic force_pulse();
    force_read = 1'b1;
    step();
    force_read = 1'b0;
  endtask

  task automatic wait_bc(input logic [15:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (burst_count == target) begin
        ok = 1'b1;
        break;
      end
    end
    step(3);
  endtask

  function automatic logic [63:0] got_bytes(input int from);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) if (from + i < got.size()) w[63 - 8*i -: 8] = got[from + i];
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_checks++;
    if (spi_clk !== 1'b0 || m_valid !== 1'b0 || meb_hold !== 1'b0 || burst_abort !== 1'b0 || spi_mosi !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs spi_clk=%b m_valid=%b meb_hold=%b abort=%b mosi=%b want all 0",
               spi_clk, m_valid, meb_hold, burst_abort, spi_mosi);
    end
    n_checks++;
    if (hit_count !== 16'd0 || burst_count !== 16'd0 || m_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_counters hit=%0d burst=%0d m_data=%h want 0/0/00", hit_count, burst_count, m_data);
    end
    rst = 1'b0;
    step(4);
    n_checks++;
    if (dut.state !== IDLE || hit_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_release state=%0d hit=%0d want IDLE/0", dut.state, hit_count);
    end
  endtask

  task automatic test_hit_readout();
    int g0, first_rise, second_rise;
    bit ok;
    logic prev;
    fee_load(64'hA53CFFFF_00000000, 4);
    g0 = got.size();
    hit_pulse();
    first_rise = -1;
    second_rise = -1;
    prev = spi_clk;
    for (int c = 0; c < 200 && second_rise < 0; c++) begin
      step();
      if (!prev && spi_clk) begin
        if (first_rise < 0) first_rise = c;
        else second_rise = c;
      end
      prev = spi_clk;
    end
    n_checks++;
    if (first_rise < 0 || second_rise - first_rise != 8) begin
      n_bad++;
      $display("FAIL spi_period got=%0d want=8 sysclk", second_rise - first_rise);
    end
    n_checks++;
    if (spi_mosi !== 1'b0) begin
      n_bad++;
      $display("FAIL mosi_cmd got=%b want=0", spi_mosi);
    end
    wait_bc(16'd1, ok);
    n_checks++;
    if (!ok) begin
      n_bad++;
      $display("FAIL hit_burst_end burst_count=%0d want=1", burst_count);
    end
    n_checks++;
    if (got.size() - g0 != 4 || got_bytes(g0) !== 64'hA53CFFFF_00000000) begin
      n_bad++;
      $display("FAIL hit_bytes n=%0d got=%h want 4 bytes a53cffff", got.size() - g0, got_bytes(g0));
    end
    n_checks++;
    if (hit_count !== 16'd1 || burst_abort !== 1'b0 || dut.state !== IDLE) begin
      n_bad++;
      $display("FAIL hit_final hit=%0d abort=%b state=%0d want 1/0/IDLE", hit_count, burst_abort, dut.state);
    end
  endtask

  task automatic test_backpressure();
    int g0, r0;
    bit ok;
    fee_load(64'h1122FFFF_00000000, 4);
    g0 = got.size();
    force_pulse();
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (m_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    m_ready = 1'b0;
    n_checks++;
    if (!ok || m_data !== 8'h11 || meb_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_first seen=%b m_data=%h hold=%b want 1/11/0", ok, m_data, meb_hold);
    end
    step();
    n_checks++;
    if (meb_hold !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_hold got=%b want=1", meb_hold);
    end
    step(150);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h11 || dut.state !== GAP || spi_clk !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_stall valid=%b data=%h state=%0d spi_clk=%b want 1/11/GAP/0",
               m_valid, m_data, dut.state, spi_clk);
    end
    r0 = spi_rises;
    step(40);
    n_checks++;
    if (spi_rises != r0 || got.size() != g0 || meb_hold !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_frozen rises=%0d accepted=%0d hold=%b want 0/0/1", spi_rises - r0, got.size() - g0, meb_hold);
    end
    m_ready = 1'b1;
    step();
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h22 || meb_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release valid=%b data=%h hold=%b want 1/22/0", m_valid, m_data, meb_hold);
    end
    wait_bc(16'd2, ok);
    n_checks++;
    if (!ok || got.size() - g0 != 4 || got_bytes(g0) !== 64'h1122FFFF_00000000) begin
      n_bad++;
      $display("FAIL bp_bytes done=%b n=%0d got=%h want 4 bytes 1122ffff", ok, got.size() - g0, got_bytes(g0));
    end
  endtask

  task automatic test_busy_gating();
    int g0, r0;
    bit ok;
    fee_busy = 1'b1;
    step(4);
    fee_load(64'h5AFFFF00_00000000, 3);
    g0 = got.size();
    r0 = spi_rises;
    hit_pulse();
    step(60);
    n_checks++;
    if (spi_rises != r0 || dut.state !== WAIT_BUSY || spi_clk !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_wait rises=%0d state=%0d want 0/WAIT_BUSY", spi_rises - r0, dut.state);
    end
    fee_busy = 1'b0;
    step(2);
    n_checks++;
    if (dut.state !== WAIT_BUSY || spi_rises != r0) begin
      n_bad++;
      $display("FAIL busy_sync_delay state=%0d rises=%0d want WAIT_BUSY/0", dut.state, spi_rises - r0);
    end
    step();
    n_checks++;
    if (dut.state !== SHIFT) begin
      n_bad++;
      $display("FAIL busy_release state=%0d want SHIFT", dut.state);
    end
    wait_bc(16'd3, ok);
    n_checks++;
    if (!ok || hit_count !== 16'd2 || got.size() - g0 != 3 || got_bytes(g0) !== 64'h5AFFFF00_00000000) begin
      n_bad++;
      $display("FAIL busy_bytes done=%b hit=%0d n=%0d got=%h want 1/2/3/5affff", ok, hit_count, got.size() - g0, got_bytes(g0));
    end
  endtask

  task automatic test_hit_during_burst();
    int g0;
    bit ok;
    fee_load(64'h0102FFFF_03FFFF00, 7);
    g0 = got.size();
    hit_pulse();
    step(40);
    hit_pulse();
    wait_bc(16'd5, ok);
    n_checks++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rehit_bursts burst_count=%0d want=5", burst_count);
    end
    n_checks++;
    if (hit_count !== 16'd4) begin
      n_bad++;
      $display("FAIL rehit_hit_count got=%0d want=4", hit_count);
    end
    n_checks++;
    if (got.size() - g0 != 7 || got_bytes(g0) !== 64'h0102FFFF_03FFFF00) begin
      n_bad++;
      $display("FAIL rehit_bytes n=%0d got=%h want 7 bytes 0102ffff03ffff", got.size() - g0, got_bytes(g0));
    end
  endtask

  task automatic test_cap();
    int g0;
    bit ok;
    fee_load(64'h10203040_50600000, 6);
    g0 = got.size();
    force_pulse();
    step(100);
    force_pulse();
    wait_bc(16'd6, ok);
    step(200);
    n_checks++;
    if (!ok || got.size() - g0 != 4 || got_bytes(g0) !== 64'h10203040_00000000) begin
      n_bad++;
      $display("FAIL cap_bytes done=%b n=%0d got=%h want 4 bytes 10203040", ok, got.size() - g0, got_bytes(g0));
    end
    n_checks++;
    if (burst_abort !== 1'b1) begin
      n_bad++;
      $display("FAIL cap_abort got=%b want=1", burst_abort);
    end
    n_checks++;
    if (dut.state !== IDLE || burst_count !== 16'd6) begin
      n_bad++;
      $display("FAIL cap_idle state=%0d burst=%0d want IDLE/6", dut.state, burst_count);
    end
  endtask

  task automatic test_reset_mid_shift();
    int g0, r0;
    bit ok;
    fee_load(64'hC3FFFF00_00000000, 3);
    g0 = got.size();
    r0 = spi_rises;
    force_pulse();
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (spi_rises - r0 >= 4) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (!ok || spi_clk !== 1'b0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid reached_bit3=%b spi_clk=%b m_valid=%b want 1/0/0", ok, spi_clk, m_valid);
    end
    n_checks++;
    if (hit_count !== 16'd0 || burst_count !== 16'd0 || burst_abort !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_counters hit=%0d burst=%0d abort=%b want 0/0/0", hit_count, burst_count, burst_abort);
    end
    rst = 1'b0;
    step(150);
    n_checks++;
    if (got.size() != g0 || m_valid !== 1'b0 || dut.state !== IDLE) begin
      n_bad++;
      $display("FAIL rst_no_partial accepted=%0d valid=%b state=%0d want 0/0/IDLE", got.size() - g0, m_valid, dut.state);
    end
  endtask

  initial begin
    test_reset();
    test_hit_readout();
    test_backpressure();
    test_busy_gating();
    test_hit_during_burst();
    test_cap();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
